// File: rtl/max_pool_2x2.sv
// max_pool_2x2: streaming 2x2 stride-2 pooling of raster pixels; average pooling when POOL_AVG_EN is defined.
// Latency: pooled pixel and outValid are registered on the edge that accepts the odd-row, odd-column pixel.
// Backpressure: none; one pixel is consumed per inValid cycle, and bubbles anywhere simply hold state.
module max_pool_2x2 #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 538
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] inputPixel,
  input  logic                 inValid,
  input  logic                 frameStart,
  output logic [WORD_SIZE-1:0] outputPixel,
  output logic                 outValid,
  output logic                 outRowEnd
);

  // Pooled pixels per output row; also the line-buffer depth.
  localparam int OUT_ROW_SIZE = ROW_SIZE / 2;
  localparam int COL_W        = (ROW_SIZE > 2) ? $clog2(ROW_SIZE) : 1;
  localparam int ADDR_W       = (OUT_ROW_SIZE > 1) ? $clog2(OUT_ROW_SIZE) : 1;
  localparam bit ODD_ROW_LEN  = (ROW_SIZE % 2) == 1;

`ifdef POOL_AVG_EN
  // The line buffer keeps the full pair sum so the final divide sees all four pixels.
  localparam int LB_W = WORD_SIZE + 1;
`else
  localparam int LB_W = WORD_SIZE;
`endif

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(ROW_SIZE - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_ROW_SIZE - 1);

  // Position of the next accepted pixel within the frame.
  logic [COL_W-1:0]     col;
  logic                 rowOdd;
  // First pixel of the current horizontal pair.
  logic [WORD_SIZE-1:0] pairHold;
  // Pair results from the even row, consumed by the odd row below it.
  logic [LB_W-1:0]      lineBuf [OUT_ROW_SIZE];

  logic [ADDR_W-1:0]    addr;
  logic                 last_col;
  logic                 skip;
  logic                 take;
  logic [LB_W-1:0]      lineVal;
  logic [LB_W-1:0]      pairVal;
  logic [WORD_SIZE-1:0] blockVal;
`ifdef POOL_AVG_EN
  logic [WORD_SIZE+1:0] sum4;
`endif

  assign addr     = ADDR_W'(col >> 1);
  assign last_col = (col == LAST_COL);
  // The unpaired trailing column of an odd-width row only advances the counters.
  assign skip     = ODD_ROW_LEN && last_col;
  // Pixel contributes data: accepted, not a frame restart, not the discarded column.
  assign take     = inValid && !frameStart && !skip;
  // Write happens on even rows and read on odd rows, so the asynchronous read never races the write.
  assign lineVal  = lineBuf[addr];

  // Combine the held pixel with the incoming one, then with the stored pair from the row above.
  always_comb begin
    pairVal  = '0;
    blockVal = '0;
`ifdef POOL_AVG_EN
    sum4     = '0;
    pairVal  = {1'b0, pairHold} + {1'b0, inputPixel};
    sum4     = {1'b0, lineVal} + {1'b0, pairVal};
    // Four WORD_SIZE values sum to WORD_SIZE+2 bits; dropping two LSBs truncates the mean.
    blockVal = WORD_SIZE'(sum4 >> 2);
`else
    pairVal  = (inputPixel > pairHold) ? inputPixel : pairHold;
    blockVal = (lineVal > pairVal) ? lineVal : pairVal;
`endif
  end

  // Counters, pair capture and registered output strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col         <= '0;
      rowOdd      <= 1'b0;
      pairHold    <= '0;
      outputPixel <= '0;
      outValid    <= 1'b0;
      outRowEnd   <= 1'b0;
    end else begin
      outValid  <= 1'b0;
      outRowEnd <= 1'b0;
      if (frameStart) begin
        // Abandon any partial block; a pixel arriving now becomes row 0, col 0.
        rowOdd <= 1'b0;
        if (inValid) begin
          pairHold <= inputPixel;
          col      <= COL_W'(1);
        end else begin
          col <= '0;
        end
      end else if (inValid) begin
        if (last_col) begin
          col    <= '0;
          rowOdd <= ~rowOdd;
        end else begin
          col <= col + COL_W'(1);
        end
        if (take) begin
          if (!col[0]) begin
            pairHold <= inputPixel;
          end else if (rowOdd) begin
            outputPixel <= blockVal;
            outValid    <= 1'b1;
            outRowEnd   <= (addr == LAST_ADDR);
          end
        end
      end
    end
  end

  // Even-row pair results are parked here; no reset since each entry is written before being read.
  always_ff @(posedge clk) begin
    if (take && col[0] && !rowOdd) begin
      lineBuf[addr] <= pairVal;
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: two instances (even and odd row length) driven with directed and random frames.
// Expected pooled values come from a block-level model over whole frames.
module tb_max_pool_2x2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] pix4, pix5;
  logic       vld4, vld5, fs4, fs5;
  logic [7:0] o4_pix, o5_pix;
  logic       o4_vld, o5_vld, o4_end, o5_end;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] q4_pix[$];
  bit         q4_end[$];
  int         q4_cyc[$];
  logic [7:0] q5_pix[$];
  bit         q5_end[$];

  max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(4)) u4 (
    .clk(clk), .rst(rst), .inputPixel(pix4), .inValid(vld4), .frameStart(fs4),
    .outputPixel(o4_pix), .outValid(o4_vld), .outRowEnd(o4_end)
  );

  max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(5)) u5 (
    .clk(clk), .rst(rst), .inputPixel(pix5), .inValid(vld5), .frameStart(fs5),
    .outputPixel(o5_pix), .outValid(o5_vld), .outRowEnd(o5_end)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every strobe shortly after the edge, tagged with the edge number.
  always @(posedge clk) begin
    #2;
    if (o4_vld === 1'b1) begin
      q4_pix.push_back(o4_pix);
      q4_end.push_back(o4_end);
      q4_cyc.push_back(cyc);
    end
    if (o5_vld === 1'b1) begin
      q5_pix.push_back(o5_pix);
      q5_end.push_back(o5_end);
    end
  end

  // Reference pooling of one 2x2 block.
  function automatic logic [7:0] ref_pool(input int a, input int b, input int c, input int d);
    int m;
`ifdef POOL_AVG_EN
    m = (a + b + c + d) / 4;
`else
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
`endif
    return 8'(m);
  endfunction

  task automatic clear_q();
    q4_pix.delete(); q4_end.delete(); q4_cyc.delete();
    q5_pix.delete(); q5_end.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld4 = 1'b0; fs4 = 1'b0; vld5 = 1'b0; fs5 = 1'b0;
    end
  endtask

  // Present one pixel to the selected instance; acc is the edge that accepts it.
  task automatic drive(input int sel, input int p, input logic v, input logic f, output int acc);
    @(negedge clk);
    vld4 = 1'b0; fs4 = 1'b0; vld5 = 1'b0; fs5 = 1'b0;
    if (sel == 4) begin pix4 = 8'(p); vld4 = v; fs4 = f; end
    else          begin pix5 = 8'(p); vld5 = v; fs5 = f; end
    acc = cyc + 1;
  endtask

  task automatic feed(input int sel, input int px[5], input int len, input int gap, output int acc[5]);
    for (int i = 0; i < 5; i++) acc[i] = -1;
    for (int i = 0; i < len; i++) begin
      idle(gap);
      drive(sel, px[i], 1'b1, 1'b0, acc[i]);
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (o4_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld4 got %b want 0", o4_vld); end
    n_cmp++; if (o4_pix !== 8'd0) begin n_err++; $display("FAIL reset_pix4 got %0d want 0", o4_pix); end
    n_cmp++; if (o4_end !== 1'b0) begin n_err++; $display("FAIL reset_end4 got %b want 0", o4_end); end
    n_cmp++; if (o5_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld5 got %b want 0", o5_vld); end
    n_cmp++; if (o5_pix !== 8'd0) begin n_err++; $display("FAIL reset_pix5 got %0d want 0", o5_pix); end
  endtask

  // Two rows of four pixels, with 'gap' idle cycles before each pixel.
  task automatic test_basic(input int gap, input string tag);
    int r0[5] = '{10, 20, 30, 5, 0};
    int r1[5] = '{15, 25, 1, 2, 0};
    int a0[5], a1[5];
    logic [7:0] e0, e1;
    clear_q();
    feed(4, r0, 4, gap, a0);
    feed(4, r1, 4, gap, a1);
    idle(4);
    e0 = ref_pool(10, 20, 15, 25);
    e1 = ref_pool(30, 5, 1, 2);
    n_cmp++;
    if (q4_pix.size() !== 2) begin
      n_err++; $display("FAIL %s_count got %0d want 2", tag, q4_pix.size());
    end else begin
      n_cmp++; if (q4_pix[0] !== e0) begin n_err++; $display("FAIL %s_pix0 got %0d want %0d", tag, q4_pix[0], e0); end
      n_cmp++; if (q4_pix[1] !== e1) begin n_err++; $display("FAIL %s_pix1 got %0d want %0d", tag, q4_pix[1], e1); end
      n_cmp++; if (q4_end[0] !== 1'b0) begin n_err++; $display("FAIL %s_end0 got %b want 0", tag, q4_end[0]); end
      n_cmp++; if (q4_end[1] !== 1'b1) begin n_err++; $display("FAIL %s_end1 got %b want 1", tag, q4_end[1]); end
      n_cmp++; if (q4_cyc[0] !== a1[1]) begin n_err++; $display("FAIL %s_lat0 got edge %0d want %0d", tag, q4_cyc[0], a1[1]); end
      n_cmp++; if (q4_cyc[1] !== a1[3]) begin n_err++; $display("FAIL %s_lat1 got edge %0d want %0d", tag, q4_cyc[1], a1[3]); end
    end
  endtask

  task automatic test_odd_row();
    int rows[4][5] = '{'{1, 2, 3, 4, 99}, '{5, 6, 7, 8, 99}, '{10, 20, 30, 40, 99}, '{1, 2, 3, 4, 99}};
    int acc[5];
    logic [7:0] ev[$];
    bit ee[$];
    clear_q();
    for (int r = 0; r < 4; r++) feed(5, rows[r], 5, 0, acc);
    idle(4);
    for (int r = 0; r < 4; r += 2)
      for (int j = 0; j < 2; j++) begin
        ev.push_back(ref_pool(rows[r][2*j], rows[r][2*j+1], rows[r+1][2*j], rows[r+1][2*j+1]));
        ee.push_back(j == 1);
      end
    n_cmp++;
    if (q5_pix.size() !== ev.size()) begin
      n_err++; $display("FAIL oddrow_count got %0d want %0d", q5_pix.size(), ev.size());
    end else begin
      for (int i = 0; i < ev.size(); i++) begin
        n_cmp++; if (q5_pix[i] !== ev[i]) begin n_err++; $display("FAIL oddrow_pix%0d got %0d want %0d", i, q5_pix[i], ev[i]); end
        n_cmp++; if (q5_end[i] !== ee[i]) begin n_err++; $display("FAIL oddrow_end%0d got %b want %b", i, q5_end[i], ee[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int r0[5] = '{10, 20, 30, 5, 0};
    int z[5]  = '{0, 0, 0, 0, 0};
    int n9[5] = '{9, 9, 9, 9, 0};
    int acc[5];
    logic [7:0] e;
    clear_q();
    feed(4, r0, 4, 0, acc);
    drive(4, 15, 1'b1, 1'b0, acc[0]);
    drive(4, 25, 1'b1, 1'b0, acc[1]);
    @(posedge clk);
    #3;
    n_cmp++; if (o4_vld !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_vld got %b want 1", o4_vld); end
    rst = 1'b1; vld4 = 1'b0;
    #1;
    n_cmp++; if (o4_vld !== 1'b0) begin n_err++; $display("FAIL rstmid_vld got %b want 0", o4_vld); end
    n_cmp++; if (o4_pix !== 8'd0) begin n_err++; $display("FAIL rstmid_pix got %0d want 0", o4_pix); end
    @(negedge clk);
    rst = 1'b0;
    clear_q();
    feed(4, z, 4, 0, acc);
    feed(4, n9, 4, 0, acc);
    idle(4);
    e = ref_pool(0, 0, 9, 9);
    n_cmp++;
    if (q4_pix.size() !== 2) begin
      n_err++; $display("FAIL rstmid_count got %0d want 2", q4_pix.size());
    end else begin
      n_cmp++; if (q4_pix[0] !== e) begin n_err++; $display("FAIL rstmid_pix0 got %0d want %0d", q4_pix[0], e); end
      n_cmp++; if (q4_pix[1] !== e) begin n_err++; $display("FAIL rstmid_pix1 got %0d want %0d", q4_pix[1], e); end
    end
  endtask

  task automatic test_frame_start();
    int r0[5] = '{10, 20, 30, 5, 0};
    int nr[5] = '{4, 5, 6, 1, 0};
    int acc[5];
    int a;
    logic [7:0] ev[3];
    clear_q();
    feed(4, r0, 4, 0, acc);
    drive(4, 15, 1'b1, 1'b0, a);
    drive(4, 25, 1'b1, 1'b0, a);
    drive(4, 1, 1'b1, 1'b0, a);
    drive(4, 200, 1'b1, 1'b1, a);
    drive(4, 3, 1'b1, 1'b0, a);
    drive(4, 7, 1'b1, 1'b0, a);
    drive(4, 8, 1'b1, 1'b0, a);
    feed(4, nr, 4, 0, acc);
    idle(4);
    ev[0] = ref_pool(10, 20, 15, 25);
    ev[1] = ref_pool(200, 3, 4, 5);
    ev[2] = ref_pool(7, 8, 6, 1);
    n_cmp++;
    if (q4_pix.size() !== 3) begin
      n_err++; $display("FAIL fstart_count got %0d want 3", q4_pix.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (q4_pix[i] !== ev[i]) begin n_err++; $display("FAIL fstart_pix%0d got %0d want %0d", i, q4_pix[i], ev[i]); end
      end
      n_cmp++; if (q4_end[2] !== 1'b1) begin n_err++; $display("FAIL fstart_end got %b want 1", q4_end[2]); end
    end
  endtask

`ifdef POOL_AVG_EN
  task automatic test_avg();
    int r0[5] = '{255, 255, 1, 2, 0};
    int r1[5] = '{255, 254, 3, 4, 0};
    int acc[5];
    clear_q();
    feed(4, r0, 4, 0, acc);
    feed(4, r1, 4, 0, acc);
    idle(4);
    n_cmp++;
    if (q4_pix.size() !== 2) begin
      n_err++; $display("FAIL avg_count got %0d want 2", q4_pix.size());
    end else begin
      n_cmp++; if (q4_pix[0] !== 8'd254) begin n_err++; $display("FAIL avg_sat got %0d want 254", q4_pix[0]); end
      n_cmp++; if (q4_pix[1] !== 8'd2) begin n_err++; $display("FAIL avg_small got %0d want 2", q4_pix[1]); end
    end
  endtask
`endif

  // Random 6-row frames with random bubbles on the odd-width instance.
  task automatic test_random();
    int frame[6][5];
    logic [7:0] ev[$];
    bit ee[$];
    int a;
    clear_q();
    drive(5, 0, 1'b0, 1'b1, a);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 5; c++) begin
        frame[r][c] = int'($urandom_range(0, 255));
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        drive(5, frame[r][c], 1'b1, 1'b0, a);
      end
    idle(4);
    for (int r = 0; r < 6; r += 2)
      for (int j = 0; j < 2; j++) begin
        ev.push_back(ref_pool(frame[r][2*j], frame[r][2*j+1], frame[r+1][2*j], frame[r+1][2*j+1]));
        ee.push_back(j == 1);
      end
    n_cmp++;
    if (q5_pix.size() !== ev.size()) begin
      n_err++; $display("FAIL rand_count got %0d want %0d", q5_pix.size(), ev.size());
    end else begin
      for (int i = 0; i < ev.size(); i++) begin
        n_cmp++; if (q5_pix[i] !== ev[i]) begin n_err++; $display("FAIL rand_pix%0d got %0d want %0d", i, q5_pix[i], ev[i]); end
        n_cmp++; if (q5_end[i] !== ee[i]) begin n_err++; $display("FAIL rand_end%0d got %b want %b", i, q5_end[i], ee[i]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pix4 = 8'd0; pix5 = 8'd0;
    vld4 = 1'b0; vld5 = 1'b0; fs4 = 1'b0; fs5 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic(0, "basic");
    test_basic(1, "bubble");
    test_odd_row();
    test_reset_mid();
    test_frame_start();
`ifdef POOL_AVG_EN
    test_avg();
`endif
    for (int k = 0; k < 4; k++) test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
